// File: rtl/piso_shift_ctrl_if.sv
// Handshake, control and serial-output bundle between a word producer, the PISO sequencer
// and a bit-serial consumer.
interface piso_shift_ctrl_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  din;
    logic          hold;
    logic          abort;
    logic          sout;
    logic          sout_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_cnt;

    modport master (
        output in_valid, din, hold, abort,
        input  in_ready, sout, sout_valid, busy, done, bit_cnt
    );

    modport slave (
        input  in_valid, din, hold, abort,
        output in_ready, sout, sout_valid, busy, done, bit_cnt
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out sequencer: accepts a word on valid/ready, shifts it out one bit per
// cycle, honours a downstream hold and a synchronous abort, and pulses done after the last bit.
module piso_shift_ctrl #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              resetn,
    piso_shift_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shifted;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          consume;
    logic          last_bit;

    // Abort outranks both accepting a new word and consuming a bit.
    assign accept   = (state == IDLE)  && bus.in_valid && !bus.abort;
    assign consume  = (state == SHIFT) && !bus.hold    && !bus.abort;
    assign last_bit = (cnt == LAST);
    assign shifted  = LSB_FIRST ? {1'b0, shreg[N-1:1]} : {shreg[N-2:0], 1'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (bus.abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) next_state = SHIFT;
                SHIFT:   if (consume && last_bit) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The counter returns to zero on the final consume so it never wraps mid-word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bus.abort) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= bus.din;
            cnt   <= '0;
        end else if (consume) begin
            shreg <= shifted;
            cnt   <= last_bit ? '0 : cnt + CW'(1);
        end
    end

    always_comb begin
        bus.in_ready   = (state == IDLE);
        bus.sout_valid = (state == SHIFT);
        bus.busy       = (state == SHIFT) || (state == DONE);
        bus.done       = (state == DONE);
        bus.bit_cnt    = cnt;
        bus.sout       = 1'b0;
        if (state == SHIFT) begin
            bus.sout = LSB_FIRST ? shreg[0] : shreg[N-1];
        end
    end
endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Drives an MSB-first and an LSB-first sequencer with identical stimulus and compares both
// against a cycle-level reference that tracks only the accepted word and the bit position.
module tb_piso_shift_ctrl;
    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         iv     = 1'b0;
    logic         hd     = 1'b0;
    logic         ab     = 1'b0;
    logic [N-1:0] d      = '0;

    int tests    = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference: phase -1 = idle, 0..N-1 = bit being presented, N = done cycle.
    int           phase = -1;
    logic [N-1:0] word  = '0;

    always #5 clk = ~clk;

    piso_shift_ctrl_if #(.N(N)) bus_msb ();
    piso_shift_ctrl_if #(.N(N)) bus_lsb ();

    assign bus_msb.in_valid = iv;
    assign bus_msb.din      = d;
    assign bus_msb.hold     = hd;
    assign bus_msb.abort    = ab;
    assign bus_lsb.in_valid = iv;
    assign bus_lsb.din      = d;
    assign bus_lsb.hold     = hd;
    assign bus_lsb.abort    = ab;

    piso_shift_ctrl #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_msb)
    );

    piso_shift_ctrl #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_lsb)
    );

    task automatic modelEdge();
        if (!resetn || ab) begin
            phase = -1;
        end else if (phase == -1) begin
            if (iv) begin
                word  = d;
                phase = 0;
            end
        end else if (phase < N) begin
            if (!hd) phase = phase + 1;
        end else begin
            phase = -1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic          sh;
        logic [CW-1:0] ec;
        logic          bm;
        logic          bl;
        logic [CW+4:0] exp_m;
        logic [CW+4:0] exp_l;
        logic [CW+4:0] obs_m;
        logic [CW+4:0] obs_l;
        sh = (phase >= 0) && (phase < N);
        ec = '0;
        bm = 1'b0;
        bl = 1'b0;
        if (sh) begin
            ec = CW'(phase);
            bm = word[N-1-phase];
            bl = word[phase];
        end
        exp_m = {phase == -1, sh, phase >= 0, phase == N, ec, bm};
        exp_l = {phase == -1, sh, phase >= 0, phase == N, ec, bl};
        obs_m = {bus_msb.in_ready, bus_msb.sout_valid, bus_msb.busy, bus_msb.done,
                 bus_msb.bit_cnt, bus_msb.sout};
        obs_l = {bus_lsb.in_ready, bus_lsb.sout_valid, bus_lsb.busy, bus_lsb.done,
                 bus_lsb.bit_cnt, bus_lsb.sout};
        tests++;
        assert (obs_m === exp_m) else begin
            failures++;
            $error("[TB] FAIL %s msb_first cycle=%0d {rdy,sv,busy,done,cnt,sout} obs=%h exp=%h",
                   tag, cycle, obs_m, exp_m);
        end
        tests++;
        assert (obs_l === exp_l) else begin
            failures++;
            $error("[TB] FAIL %s lsb_first cycle=%0d {rdy,sv,busy,done,cnt,sout} obs=%h exp=%h",
                   tag, cycle, obs_l, exp_l);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] w, input logic h,
                                 input logic a, input string tag);
        iv = v;
        d  = w;
        hd = h;
        ab = a;
        @(posedge clk);
        modelEdge();
        #1;
        cycle++;
        checkOutput(tag);
    endtask

    initial begin
        int acc[$];

        #1;
        checkOutput("reset_initial");
        // A word offered during reset must not be taken.
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, "reset_no_accept");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, "reset_no_accept");
        resetn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "reset_idle");

        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, "t1_load");
        repeat (N + 2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t1_shift");

        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, "t3_load");
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t3_shift");
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "t3_hold");
        repeat (N) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t3_resume");

        applyStimulus(1'b1, 8'h96, 1'b0, 1'b0, "t4_load");
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t4_shift");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, "t4_abort");
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, "t4_reload");
        repeat (N + 2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t4_shift2");

        // Back-to-back words: accept edges are recorded from the DUT handshake.
        d = 8'hFF;
        for (int i = 0; i < 2 * (N + 2) + 2; i++) begin
            if (bus_msb.in_ready && iv) acc.push_back(cycle + 1);
            applyStimulus(1'b1, (acc.size() == 0) ? 8'hFF : 8'h00, 1'b0, 1'b0, "t5_stream");
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t5_stream");
        repeat (N + 2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t5_drain");
        tests++;
        assert (acc.size() >= 2) else begin
            failures++;
            $error("[TB] FAIL t5_accepts count obs=%0d exp>=2", acc.size());
        end
        if (acc.size() >= 2) begin
            tests++;
            assert (acc[1] - acc[0] == N + 2) else begin
                failures++;
                $error("[TB] FAIL t5_period obs=%0d exp=%0d", acc[1] - acc[0], N + 2);
            end
        end

        applyStimulus(1'b1, 8'hE7, 1'b0, 1'b0, "t6_load");
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t6_shift");
        #3 resetn = 1'b0;
        #1 phase = -1;
        checkOutput("t6_async_reset");
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, "t6_in_reset");
        #3 resetn = 1'b1;
        applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, "t6_load");
        repeat (N + 2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "t6_shift");

        repeat (400) begin
            applyStimulus($urandom_range(0, 2) != 0, N'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 24) == 0, "random");
        end
        repeat (N + 2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
